// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if : hazard-controller request/response bundle
// Rev 1.0 ; optional perf counters with HAZARD_PERF_CNT_EN
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_hazard_ctrl_if;
  logic       riscv_start;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs1;
  logic       if_id_use_rs2;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic       id_ex_md_type;
  logic [2:0] id_ex_md_op;
  logic       ex_redirect;
  logic       dcache_busy;
  logic       mem_wb_ecall;

  logic       flush;
  logic       load_use_stall;
  logic       md_alu_stall;
  logic       dcache_stall;
  logic       md_start;
  logic       riscv_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_md_cnt;
  logic [31:0] perf_dc_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
    output riscv_start, if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_mem_read, id_ex_rd, id_ex_md_type, id_ex_md_op,
           ex_redirect, dcache_busy, mem_wb_ecall,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_lu_cnt, perf_md_cnt, perf_dc_cnt, perf_flush_cnt,
`endif
    input  flush, load_use_stall, md_alu_stall, dcache_stall, md_start,
           riscv_done
  );

  modport slave (
    input  riscv_start, if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
           id_ex_mem_read, id_ex_rd, id_ex_md_type, id_ex_md_op,
           ex_redirect, dcache_busy, mem_wb_ecall,
`ifdef HAZARD_PERF_CNT_EN
    output perf_lu_cnt, perf_md_cnt, perf_dc_cnt, perf_flush_cnt,
`endif
    output flush, load_use_stall, md_alu_stall, dcache_stall, md_start,
           riscv_done
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush sequencer and run-control FSM (RV32IM)
// Rev 1.0 ; HAZARD_PERF_CNT_EN adds saturating per-control event counters
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input wire                      clk,
  input wire                      reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic             C_MUL_ONE  = (MUL_LAT == 1);
  localparam logic             C_DIV_ONE  = (DIV_LAT == 1);

  run_state_t       r_run_state;
  run_state_t       w_run_next;
  md_state_t        r_md_state;
  md_state_t        w_md_next;
  logic [CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] w_md_cnt_next;
  logic             r_done;

  logic             w_run;
  logic             w_md_trig;
  logic [CNT_W-1:0] w_md_load;
  logic             w_md_one;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_dcache_stall;
  logic             w_md_alu_stall;
  logic             w_md_start;
  logic             w_load_use;
  logic             w_flush;
  logic             w_unused_md_op;

  // Only bit 2 of funct3 selects MUL vs DIV latency.
  assign w_unused_md_op = ^hz.id_ex_md_op[1:0];

  assign w_run     = (r_run_state == RUN);
  assign w_md_trig = (r_md_state == MD_IDLE) & hz.id_ex_md_type & ~hz.dcache_busy;
  assign w_md_load = hz.id_ex_md_op[2] ? C_DIV_LOAD : C_MUL_LOAD;
  assign w_md_one  = hz.id_ex_md_op[2] ? C_DIV_ONE  : C_MUL_ONE;
  assign w_hit_rs1 = hz.if_id_use_rs1 & (hz.if_id_rs1 == hz.id_ex_rd);
  assign w_hit_rs2 = hz.if_id_use_rs2 & (hz.if_id_rs2 == hz.id_ex_rd);

  always_comb begin
    w_dcache_stall = 1'b0;
    w_md_alu_stall = 1'b0;
    w_md_start     = 1'b0;
    w_load_use     = 1'b0;
    w_flush        = 1'b0;
    if (w_run) begin
      w_dcache_stall = hz.dcache_busy;
      w_md_start     = w_md_trig;
      w_md_alu_stall = (r_md_state == MD_BUSY) | w_md_trig;
      w_load_use     = hz.id_ex_mem_read & (hz.id_ex_rd != 5'd0) &
                       (w_hit_rs1 | w_hit_rs2) &
                       ~w_dcache_stall & ~w_md_alu_stall;
      // A frozen EX keeps presenting the redirect, so it is safe to defer.
      w_flush        = hz.ex_redirect & ~w_dcache_stall & ~w_md_alu_stall;
    end
  end

  always_comb begin
    w_run_next = r_run_state;
    case (r_run_state)
      IDLE:    if (hz.riscv_start) w_run_next = RUN;
      RUN:     if (hz.mem_wb_ecall & ~w_dcache_stall & ~w_md_alu_stall)
                 w_run_next = DONE;
      DONE:    if (!hz.riscv_start) w_run_next = IDLE;
      default: w_run_next = IDLE;
    endcase
  end

  always_comb begin
    w_md_next     = r_md_state;
    w_md_cnt_next = r_md_cnt;
    if (!w_run || (w_run_next != RUN)) begin
      w_md_next     = MD_IDLE;
      w_md_cnt_next = '0;
    end else begin
      case (r_md_state)
        MD_IDLE: begin
          if (w_md_trig) begin
            w_md_cnt_next = w_md_load;
            w_md_next     = w_md_one ? MD_DONE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          w_md_cnt_next = r_md_cnt - 1'b1;
          if (r_md_cnt == CNT_W'(1)) w_md_next = MD_DONE;
        end
        // Hold here while MEM is frozen so the same op is not restarted.
        MD_DONE: begin
          if (!w_dcache_stall) w_md_next = MD_IDLE;
        end
        default: begin
          w_md_next     = MD_IDLE;
          w_md_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run_state <= IDLE;
      r_md_state  <= MD_IDLE;
      r_md_cnt    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_run_state <= w_run_next;
      r_md_state  <= w_md_next;
      r_md_cnt    <= w_md_cnt_next;
      r_done      <= (w_run_next == DONE);
    end
  end

  assign hz.flush          = w_flush;
  assign hz.load_use_stall = w_load_use;
  assign hz.md_alu_stall   = w_md_alu_stall;
  assign hz.dcache_stall   = w_dcache_stall;
  assign hz.md_start       = w_md_start;
  assign hz.riscv_done     = r_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_md;
  logic [31:0] r_perf_dc;
  logic [31:0] r_perf_fl;
  logic        w_perf_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign w_perf_clr = (r_run_state == IDLE) && (w_run_next == RUN);

  always_ff @(posedge clk) begin
    if (!reset || w_perf_clr) begin
      r_perf_lu <= '0;
      r_perf_md <= '0;
      r_perf_dc <= '0;
      r_perf_fl <= '0;
    end else begin
      r_perf_lu <= sat_inc(r_perf_lu, w_load_use);
      r_perf_md <= sat_inc(r_perf_md, w_md_alu_stall);
      r_perf_dc <= sat_inc(r_perf_dc, w_dcache_stall);
      r_perf_fl <= sat_inc(r_perf_fl, w_flush);
    end
  end

  assign hz.perf_lu_cnt    = r_perf_lu;
  assign hz.perf_md_cnt    = r_perf_md;
  assign hz.perf_dc_cnt    = r_perf_dc;
  assign hz.perf_flush_cnt = r_perf_fl;
`endif

endmodule

`default_nettype wire
